// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage sequencer (master) and the external data RAM (slave).
//
// Handshake: the master holds doe (read) or dwe (write) high together with stable daddr,
// dbe and dwdata until the slave acknowledges by pulling dready_n low for one cycle.
// The transfer retires on the rising edge where the strobe is high and dready_n is low.
// For reads, drdata is sampled on that same edge. While no strobe is high, dready_n is ignored.
interface dmem_access_ctrl_if;
    logic [31:0] daddr;
    logic        doe;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] dwdata;
    logic        dready_n;
    logic [31:0] drdata;

    modport master (
        output daddr, doe, dwe, dbe, dwdata,
        input  dready_n, drdata
    );

    modport slave (
        input  daddr, doe, dwe, dbe, dwdata,
        output dready_n, drdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns a load/store into one bus transaction,
// aligns store lanes and byte enables, extracts/extends load data, and stalls the
// pipeline through dbusy until the transaction retires.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic          clk,
    input  logic          rst,           // asynchronous, active low
    input  logic [1:0]    MemRW_pype2,   // [1]=load, [0]=store, 2'b11 = load
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [1:0]    mem_size,      // 00 byte, 01 half, 1x word
    input  logic          mem_unsigned,
    input  logic          nop_Mem,
    dmem_access_ctrl_if.master bus,
    output logic [31:0]   rdata,
    output logic          rdata_valid,
    output logic          dbusy,
    output logic          misalign_err,
    output logic          bus_err,
    output logic [1:0]    dbg_state_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        berr_q, berr_d;

    // Transaction parameters captured when the request is accepted.
    logic [31:0] daddr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        access_v, misalign_raw, req, in_wait;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign access_v     = (|MemRW_pype2) && !nop_Mem;
    assign misalign_raw = access_v &&
                          (((mem_size == 2'b01) && mem_addr[0]) ||
                           (mem_size[1] && (mem_addr[1:0] != 2'b00)));
    assign req          = access_v && !misalign_raw;
    assign in_wait      = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        be_new = 4'b1111;
        wd_new = mem_wdata;
        case (mem_size)
            2'b00: begin
                be_new = 4'b0001 << mem_addr[1:0];
                wd_new = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                be_new = 4'b0011 << mem_addr[1:0];
                wd_new = {2{mem_wdata[15:0]}};
            end
            default: begin
                be_new = 4'b1111;
                wd_new = mem_wdata;
            end
        endcase
    end

    // Select the addressed lane of the read word and sign/zero-extend it.
    always_comb begin
        byte_sel = bus.drdata[7:0];
        case (lane_q)
            2'd0: byte_sel = bus.drdata[7:0];
            2'd1: byte_sel = bus.drdata[15:8];
            2'd2: byte_sel = bus.drdata[23:16];
            default: byte_sel = bus.drdata[31:24];
        endcase
        half_sel = lane_q[1] ? bus.drdata[31:16] : bus.drdata[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = bus.drdata;
        endcase
    end

    // Sequencer next state: accept, wait for ack or timeout, one retire cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = MemRW_pype2[1] ? S_RD_WAIT : S_WR_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (!bus.dready_n) begin
                    state_d = S_DONE;
                    if (state_q == S_RD_WAIT) begin
                        rdata_d  = load_ext;
                        rvalid_d = 1'b1;
                    end
                end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            berr_q   <= berr_d;
        end
    end

    // Capture the request so the bus stays stable while the pipeline inputs are frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            daddr_q <= 32'd0;
            be_q    <= 4'd0;
            wd_q    <= 32'd0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
        end else if ((state_q == S_IDLE) && req) begin
            daddr_q <= {mem_addr[31:2], 2'b00};
            be_q    <= be_new;
            wd_q    <= wd_new;
            lane_q  <= mem_addr[1:0];
            size_q  <= mem_size;
            uns_q   <= mem_unsigned;
        end
    end

    // Bus is driven only while a transfer is pending; quiet otherwise.
    assign bus.doe    = (state_q == S_RD_WAIT);
    assign bus.dwe    = (state_q == S_WR_WAIT);
    assign bus.daddr  = in_wait ? daddr_q : 32'd0;
    assign bus.dbe    = in_wait ? be_q    : 4'd0;
    assign bus.dwdata = in_wait ? wd_q    : 32'd0;

    // Stall starts combinationally in the accept cycle and drops in the retire cycle.
    assign dbusy        = rst && (((state_q == S_IDLE) && req) || in_wait);
    assign misalign_err = rst && misalign_raw;
    assign rdata        = rdata_q;
    assign rdata_valid  = rvalid_q;
    assign bus_err      = berr_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
    localparam int TMO = 15;

    logic        clk;
    logic        rst;
    logic [1:0]  MemRW_pype2;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        nop_Mem;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        dbusy;
    logic        misalign_err;
    logic        bus_err;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRW_pype2  (MemRW_pype2),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .nop_Mem      (nop_Mem),
        .bus          (bus),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .dbusy        (dbusy),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .dbg_state_o  (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction: request cycle, wait cycles, retire cycle.
    // ack_at = wait cycle (1-based) with dready_n low, 0 = never acknowledge.
    task automatic access(input string tag, input logic [1:0] rw, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          input int ack_at, input logic [31:0] rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_dw, input logic nop_wait);
        int   waits;
        logic ld;
        ld    = rw[1];
        waits = (ack_at == 0) ? TMO : ack_at;
        @(negedge clk);
        MemRW_pype2  = rw;
        mem_addr     = addr;
        mem_wdata    = wd;
        mem_size     = sz;
        mem_unsigned = uns;
        nop_Mem      = 1'b0;
        bus.dready_n = 1'b1;
        bus.drdata   = 32'h0;
        #1;
        check({tag, " req_dbusy"}, 32'(dbusy), 32'd1);
        check({tag, " req_strobes"}, {30'd0, bus.doe, bus.dwe}, 32'd0);
        for (int i = 1; i <= waits; i++) begin
            @(negedge clk);
            nop_Mem = nop_wait;
            if (i == ack_at) begin
                bus.dready_n = 1'b0;
                bus.drdata   = rd;
            end else begin
                bus.dready_n = 1'b1;
                bus.drdata   = 32'hA5A5_5A5A;
            end
            #1;
            check({tag, " wait_strobes"}, {30'd0, bus.doe, bus.dwe}, {30'd0, ld, !ld});
            check({tag, " wait_dbusy"}, 32'(dbusy), 32'd1);
            check({tag, " wait_daddr"}, bus.daddr, {addr[31:2], 2'b00});
            check({tag, " wait_dbe"}, 32'(bus.dbe), 32'(exp_be));
            check({tag, " wait_dwdata"}, bus.dwdata, exp_dw);
        end
        @(negedge clk);
        nop_Mem      = 1'b0;
        bus.dready_n = 1'b1;
        #1;
        check({tag, " done_dbusy"}, 32'(dbusy), 32'd0);
        check({tag, " done_strobes"}, {30'd0, bus.doe, bus.dwe}, 32'd0);
        check({tag, " done_rvalid"}, 32'(rdata_valid), 32'(ld && (ack_at != 0)));
        check({tag, " done_buserr"}, 32'(bus_err), 32'(ack_at == 0));
    endtask

    // Pipeline presents nothing for one cycle; sequencer must be idle and quiet.
    task automatic idle(input string tag);
        @(negedge clk);
        MemRW_pype2 = 2'b00;
        nop_Mem     = 1'b0;
        #1;
        check({tag, " idle_state"}, 32'(dbg_state), 32'd0);
        check({tag, " idle_rvalid"}, 32'(rdata_valid), 32'd0);
        check({tag, " idle_buserr"}, 32'(bus_err), 32'd0);
        check({tag, " idle_dbusy"}, 32'(dbusy), 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        MemRW_pype2  = 2'b00;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        nop_Mem      = 1'b0;
        bus.dready_n = 1'b1;
        bus.drdata   = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst state", 32'(dbg_state), 32'd0);
        check("rst outs", {26'd0, bus.doe, bus.dwe, dbusy, rdata_valid, bus_err, misalign_err}, 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst dbe", 32'(bus.dbe), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle("post_rst");

        // Word load, ack in first wait cycle
        access("ld_w", 2'b10, 32'h100, 32'h0, 2'b10, 1'b0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
        check("ld_w rdata", rdata, 32'hDEAD_BEEF);
        idle("ld_w");

        // Signed and unsigned byte loads from lane 3 (second one uses MemRW=11)
        access("ld_bs", 2'b10, 32'h203, 32'h0, 2'b00, 1'b0, 1, 32'h8012_3456, 4'b1000, 32'h0, 1'b0);
        check("ld_bs rdata", rdata, 32'hFFFF_FF80);
        idle("ld_bs");
        access("ld_bu", 2'b11, 32'h203, 32'h0, 2'b00, 1'b1, 2, 32'h8012_3456, 4'b1000, 32'h0, 1'b0);
        check("ld_bu rdata", rdata, 32'h0000_0080);
        idle("ld_bu");

        // Half loads, upper half signed and lower half unsigned
        access("ld_hs", 2'b10, 32'h202, 32'h0, 2'b01, 1'b0, 1, 32'h8001_1234, 4'b1100, 32'h0, 1'b0);
        check("ld_hs rdata", rdata, 32'hFFFF_8001);
        idle("ld_hs");
        access("ld_hu", 2'b10, 32'h10, 32'h0, 2'b01, 1'b1, 1, 32'h1234_F00D, 4'b0011, 32'h0, 1'b0);
        check("ld_hu rdata", rdata, 32'h0000_F00D);
        idle("ld_hu");

        // Half store, ack after 3 wait cycles, nop_Mem raised during the wait
        access("st_h", 2'b01, 32'h42, 32'h0000_ABCD, 2'b01, 1'b0, 3, 32'h0, 4'b1100, 32'hABCD_ABCD, 1'b1);
        check("st_h rdata_kept", rdata, 32'h0000_F00D);
        idle("st_h");

        // Byte store to lane 1
        access("st_b", 2'b01, 32'h61, 32'h1234_5678, 2'b00, 1'b0, 1, 32'h0, 4'b0010, 32'h7878_7878, 1'b0);
        idle("st_b");

        // Misaligned word and half: no bus access, no stall
        @(negedge clk);
        MemRW_pype2 = 2'b10; mem_addr = 32'h101; mem_size = 2'b10;
        #1;
        check("mis_w err", 32'(misalign_err), 32'd1);
        check("mis_w dbusy", 32'(dbusy), 32'd0);
        @(negedge clk);
        #1;
        check("mis_w state", 32'(dbg_state), 32'd0);
        check("mis_w doe", 32'(bus.doe), 32'd0);
        check("mis_w err_held", 32'(misalign_err), 32'd1);
        @(negedge clk);
        MemRW_pype2 = 2'b01; mem_addr = 32'h43; mem_size = 2'b01;
        #1;
        check("mis_h err", 32'(misalign_err), 32'd1);
        check("mis_h dbusy", 32'(dbusy), 32'd0);
        @(negedge clk);
        #1;
        check("mis_h dwe", 32'(bus.dwe), 32'd0);
        // Flushed stage: neither error nor request
        @(negedge clk);
        MemRW_pype2 = 2'b10; mem_addr = 32'h101; mem_size = 2'b10; nop_Mem = 1'b1;
        #1;
        check("nop err", 32'(misalign_err), 32'd0);
        check("nop dbusy", 32'(dbusy), 32'd0);
        @(negedge clk);
        #1;
        check("nop state", 32'(dbg_state), 32'd0);
        idle("mis");

        // Stray ack while idle is ignored
        @(negedge clk);
        bus.dready_n = 1'b0; bus.drdata = 32'h1111_1111;
        @(negedge clk);
        #1;
        check("stray rvalid", 32'(rdata_valid), 32'd0);
        check("stray rdata", rdata, 32'h0000_F00D);
        bus.dready_n = 1'b1;
        idle("stray");

        // Timeout: dready_n never low
        access("tmo", 2'b10, 32'h300, 32'h0, 2'b10, 1'b0, 0, 32'h0, 4'b1111, 32'h0, 1'b0);
        check("tmo rdata_kept", rdata, 32'h0000_F00D);
        idle("tmo");

        // Back-to-back store then load
        access("b2b_st", 2'b01, 32'h80, 32'hCAFE_F00D, 2'b10, 1'b0, 2, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b0);
        access("b2b_ld", 2'b10, 32'h81, 32'h0, 2'b00, 1'b1, 1, 32'h0000_3C00, 4'b0010, 32'h0, 1'b0);
        check("b2b_ld rdata", rdata, 32'h0000_003C);
        idle("b2b");

        // Reset asserted in the middle of a read wait
        @(negedge clk);
        MemRW_pype2 = 2'b10; mem_addr = 32'h500; mem_size = 2'b10;
        #1;
        check("rstmid req_dbusy", 32'(dbusy), 32'd1);
        @(negedge clk);
        #1;
        check("rstmid doe_before", 32'(bus.doe), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid doe", 32'(bus.doe), 32'd0);
        check("rstmid dbusy", 32'(dbusy), 32'd0);
        check("rstmid state", 32'(dbg_state), 32'd0);
        check("rstmid rdata", rdata, 32'd0);
        @(negedge clk);
        MemRW_pype2 = 2'b00;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rstmid no_replay", {29'd0, bus.doe, bus.dwe, dbusy}, 32'd0);
            check("rstmid idle", 32'(dbg_state), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
